// File: rtl/twiddle_stage.sv
// -----------------------------------------------------------------------------
// twiddle_stage
//
// Consumer side of a radix-2 SDF butterfly. Each block has 2*NUM_PAIR valid
// samples. The first NUM_PAIR samples are butterfly SUM outputs and pass
// through unchanged (multiplication by W^0). The next NUM_PAIR samples are
// DIFF outputs. Each DIFF sample k is multiplied by W_N^k, which an external
// asynchronous ROM supplies. The product is then rounded half-up and saturated
// back to WIDTH+1 bits.
//
// Pipeline: stage 1 registers the four partial products together with the
// bypass data and flags. Stage 2 forms the complex product, rounds it,
// saturates it and registers the outputs. An accepted sample comes out two
// registers later. No backpressure.
//
// Ports:
//   clk        clock
//   rst        synchronous, active-high reset
//   in_valid   input sample qualifier
//   in_re/im   signed WIDTH+1 input sample
//   tw_idx     twiddle ROM address (combinational from the sample counter)
//   tw_re/im   signed COEF_W ROM data for tw_idx, sampled with in_valid
//   out_valid  output qualifier
//   out_re/im  signed WIDTH+1 twiddled sample, zero when out_valid=0
//   sat        pulses with out_valid when either component clipped
//   blk_done   pulses with out_valid on the last sample of a block
// -----------------------------------------------------------------------------
module twiddle_stage #(
  parameter int WIDTH    = 12,
  parameter int NUM_PAIR = 16,
  parameter int COEF_W   = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic signed [WIDTH:0]         in_re,
  input  logic signed [WIDTH:0]         in_im,
  output logic [$clog2(NUM_PAIR)-1:0]   tw_idx,
  input  logic signed [COEF_W-1:0]      tw_re,
  input  logic signed [COEF_W-1:0]      tw_im,
  output logic                          out_valid,
  output logic signed [WIDTH:0]         out_re,
  output logic signed [WIDTH:0]         out_im,
  output logic                          sat,
  output logic                          blk_done
);

  // ---------------------------------------------------------------------------
  // Derived widths and constants
  // ---------------------------------------------------------------------------
  localparam int DW = WIDTH + 1;               // data width
  localparam int CW = $clog2(2 * NUM_PAIR);    // sample counter width
  localparam int IW = CW - 1;                  // twiddle index width
  localparam int PW = WIDTH + COEF_W + 1;      // partial product width
  localparam int SW = PW + 1;                  // sum/difference width
  localparam int SH = COEF_W - 2;              // 1.0 == 2^SH in the coefficients

  localparam logic [CW-1:0]        LAST    = CW'(2 * NUM_PAIR - 1);
  localparam logic signed [SW-1:0] RND     = SW'(1) << (COEF_W - 3);
  localparam logic signed [DW-1:0] OUT_MAX = {1'b0, {WIDTH{1'b1}}};
  localparam logic signed [DW-1:0] OUT_MIN = {1'b1, {WIDTH{1'b0}}};
  localparam logic signed [SW-1:0] SAT_MAX = SW'(OUT_MAX);
  localparam logic signed [SW-1:0] SAT_MIN = SW'(OUT_MIN);

  typedef struct packed {
    logic          clip;
    logic [DW-1:0] val;
  } sat_t;

  // Round half-up (add one half LSB, then floor shift) and clip to DW bits.
  function automatic sat_t round_sat(input logic signed [SW-1:0] x);
    logic signed [SW-1:0] r;
    sat_t                 o;
    r = (x + RND) >>> SH;
    o.clip = 1'b0;
    o.val  = r[DW-1:0];
    if (r > SAT_MAX) begin
      o.clip = 1'b1;
      o.val  = OUT_MAX;
    end else if (r < SAT_MIN) begin
      o.clip = 1'b1;
      o.val  = OUT_MIN;
    end
    return o;
  endfunction

  // ---------------------------------------------------------------------------
  // Sample counter and twiddle address
  // ---------------------------------------------------------------------------
  logic [CW-1:0] cnt;
  logic          half;   // 0: SUM half (bypass), 1: DIFF half (multiply)

  assign half = cnt[CW-1];

  // NOTE: in always_comb every output gets a default value before any
  // conditional assignment. A path that leaves a signal unassigned infers a latch.
  always_comb begin
    tw_idx = '0;
    if (half) tw_idx = cnt[IW-1:0];
  end

  // ---------------------------------------------------------------------------
  // Stage 1: control state (reset) and datapath registers (no reset)
  // ---------------------------------------------------------------------------
  logic v1;

  // NOTE: clocked state uses non-blocking assignments. Every register then
  // sees the pre-edge value of the others, whatever the statement order.
  // The block length is a power of two, so the counter wraps by itself
  // after the last DIFF sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      v1  <= 1'b0;
    end else begin
      v1 <= in_valid;
      if (in_valid) cnt <= cnt + CW'(1);
    end
  end

  // Sign-extend the operands to the product width, so that each multiply is
  // exact at PW bits.
  logic signed [PW-1:0] in_re_x, in_im_x, tw_re_x, tw_im_x;
  assign in_re_x = PW'(in_re);
  assign in_im_x = PW'(in_im);
  assign tw_re_x = PW'(tw_re);
  assign tw_im_x = PW'(tw_im);

  logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [DW-1:0] re1, im1;
  logic                 byp1, last1;

  // NOTE: the datapath registers are left without a reset. Nothing reads them
  // unless v1 (which is reset) marks them as holding a live sample.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      p_rr  <= in_re_x * tw_re_x;
      p_ii  <= in_im_x * tw_im_x;
      p_ri  <= in_re_x * tw_im_x;
      p_ir  <= in_im_x * tw_re_x;
      re1   <= in_re;
      im1   <= in_im;
      byp1  <= ~half;
      last1 <= (cnt == LAST);
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: complex combine, round, saturate, register outputs
  // ---------------------------------------------------------------------------
  logic signed [SW-1:0] re_full, im_full;
  sat_t                 rs_re, rs_im;

  assign re_full = SW'(p_rr) - SW'(p_ii);
  assign im_full = SW'(p_ri) + SW'(p_ir);
  assign rs_re   = round_sat(re_full);
  assign rs_im   = round_sat(im_full);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      sat       <= 1'b0;
      blk_done  <= 1'b0;
    end else begin
      out_valid <= v1;
      if (v1) begin
        blk_done <= last1;
        if (byp1) begin
          out_re <= re1;
          out_im <= im1;
          sat    <= 1'b0;
        end else begin
          out_re <= rs_re.val;
          out_im <= rs_im.val;
          sat    <= rs_re.clip | rs_im.clip;
        end
      end else begin
        out_re   <= '0;
        out_im   <= '0;
        sat      <= 1'b0;
        blk_done <= 1'b0;
      end
    end
  end

endmodule
